cache_arbiter: RTL and testbench

CACHE_ARBITER -- requirements
Module: cache_arbiter

---
 rtl/cache_arbiter.sv | 96 +++++++++
 tb/tb_cache_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// Round-robin arbiter that shares one line-granular memory port between an
// I-cache (reads only) and a D-cache (reads and writebacks).
module cache_arbiter #(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,

  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,

  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_e;
  typedef enum logic {GRANT_I, GRANT_D} grant_e;

  state_e                state;
  grant_e                last_grant;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic                  lat_write;
  logic [LINE_WIDTH-1:0] lat_wdata;

  logic i_req;
  logic d_req;
  logic grant_d;
  logic busy;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;
  // D wins when it is alone, or on a tie when I had the previous grant.
  assign grant_d = d_req && (!i_req || (last_grant == GRANT_I));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GRANT_I;
      lat_addr   <= '0;
      lat_write  <= 1'b0;
      lat_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state      <= SERVE_D;
            last_grant <= GRANT_D;
            lat_addr   <= d_pmem_address;
            lat_write  <= d_pmem_write;  // read+write together is a write
            lat_wdata  <= d_pmem_wdata;
          end else if (i_req) begin
            state      <= SERVE_I;
            last_grant <= GRANT_I;
            lat_addr   <= i_pmem_address;
            lat_write  <= 1'b0;
            lat_wdata  <= '0;
          end
        end
        SERVE_I, SERVE_D: begin
          if (pmem_resp) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory-side outputs depend only on the latched transaction.
  assign busy         = (state != IDLE);
  assign pmem_read    = busy && !lat_write;
  assign pmem_write   = busy && lat_write;
  assign pmem_address = busy ? lat_addr : '0;
  assign pmem_wdata   = (busy && lat_write) ? lat_wdata : '0;

  // Completion is forwarded in the same cycle as pmem_resp.
  assign i_pmem_resp  = (state == SERVE_I) && pmem_resp;
  assign d_pmem_resp  = (state == SERVE_D) && pmem_resp;
  assign i_pmem_rdata = (state == SERVE_I) ? pmem_rdata : '0;
  assign d_pmem_rdata = (state == SERVE_D) ? pmem_rdata : '0;

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
module tb_cache_arbiter;

  localparam int LW = 256;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_pmem_read;
  logic [AW-1:0] i_pmem_address;
  logic [LW-1:0] i_pmem_rdata;
  logic          i_pmem_resp;
  logic          d_pmem_read;
  logic          d_pmem_write;
  logic [AW-1:0] d_pmem_address;
  logic [LW-1:0] d_pmem_wdata;
  logic [LW-1:0] d_pmem_rdata;
  logic          d_pmem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  cache_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: who owns the memory port and which transaction it runs.
  typedef enum {OWN_NONE, OWN_I, OWN_D} owner_e;
  typedef struct packed {
    logic [AW-1:0] addr;
    logic          write;
    logic [LW-1:0] wdata;
  } txn_t;

  owner_e m_owner;
  bit     m_last_d;
  txn_t   m_txn;

  function automatic void model_reset();
    m_owner  = OWN_NONE;
    m_last_d = 1'b0;
    m_txn    = '0;
  endfunction

  // Advance the model across one rising edge using the inputs present now.
  function automatic void model_edge();
    bit i_req;
    bit d_req;
    i_req = i_pmem_read;
    d_req = d_pmem_read || d_pmem_write;
    if (m_owner == OWN_NONE) begin
      if (d_req && (!i_req || !m_last_d)) begin
        m_owner  = OWN_D;
        m_last_d = 1'b1;
        m_txn    = '{addr: d_pmem_address, write: d_pmem_write, wdata: d_pmem_wdata};
      end else if (i_req) begin
        m_owner  = OWN_I;
        m_last_d = 1'b0;
        m_txn    = '{addr: i_pmem_address, write: 1'b0, wdata: '0};
      end
    end else if (pmem_resp) begin
      m_owner = OWN_NONE;
    end
  endfunction

  task automatic check_all(input string tag);
    bit busy;
    busy = (m_owner != OWN_NONE);
    check({tag, ".pmem_read"},    LW'(pmem_read),    LW'(busy && !m_txn.write));
    check({tag, ".pmem_write"},   LW'(pmem_write),   LW'(busy && m_txn.write));
    check({tag, ".pmem_address"}, LW'(pmem_address), busy ? LW'(m_txn.addr) : '0);
    check({tag, ".pmem_wdata"},   pmem_wdata,        (busy && m_txn.write) ? m_txn.wdata : '0);
    check({tag, ".i_resp"},       LW'(i_pmem_resp),  LW'((m_owner == OWN_I) && pmem_resp));
    check({tag, ".d_resp"},       LW'(d_pmem_resp),  LW'((m_owner == OWN_D) && pmem_resp));
    check({tag, ".i_rdata"},      i_pmem_rdata,      (m_owner == OWN_I) ? pmem_rdata : '0);
    check({tag, ".d_rdata"},      d_pmem_rdata,      (m_owner == OWN_D) ? pmem_rdata : '0);
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int k = 0; k < LW / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic clear_inputs();
    i_pmem_read    = 1'b0;
    i_pmem_address = '0;
    d_pmem_read    = 1'b0;
    d_pmem_write   = 1'b0;
    d_pmem_address = '0;
    d_pmem_wdata   = '0;
    pmem_rdata     = '0;
    pmem_resp      = 1'b0;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    #1;
    model_reset();
    check_all("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  int  d_while_i;
  int  i_while_d;
  bit  i_done;
  bit  d_done;

  initial begin
    rst = 1'b0;
    clear_inputs();
    #2;
    do_reset();

    // Lone I read
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_1000;
    #1; check_all("t_iread.idle");
    tick();
    check("t_iread.pmem_read", LW'(pmem_read), LW'(1'b1));
    check("t_iread.addr", LW'(pmem_address), LW'(32'h0000_1000));
    pmem_resp = 1'b1; pmem_rdata = {32{8'hA5}};
    #1;
    check("t_iread.i_resp", LW'(i_pmem_resp), LW'(1'b1));
    check("t_iread.i_rdata", i_pmem_rdata, {32{8'hA5}});
    check("t_iread.d_resp", LW'(d_pmem_resp), '0);
    check_all("t_iread.resp");
    tick();
    clear_inputs();

    // Tie after reset: D first, I at resp+2
    do_reset();
    i_pmem_read = 1'b1; i_pmem_address = 32'h100;
    d_pmem_write = 1'b1; d_pmem_address = 32'h200; d_pmem_wdata = {32{8'h5A}};
    tick();
    check("t_tie.d_write", LW'(pmem_write), LW'(1'b1));
    check("t_tie.d_addr", LW'(pmem_address), LW'(32'h200));
    check("t_tie.d_wdata", pmem_wdata, {32{8'h5A}});
    check_all("t_tie.serve_d");
    pmem_resp = 1'b1;
    #1;
    check("t_tie.d_resp", LW'(d_pmem_resp), LW'(1'b1));
    check("t_tie.i_resp_low", LW'(i_pmem_resp), '0);
    tick();
    d_pmem_write = 1'b0; pmem_resp = 1'b0;
    #1;
    check("t_tie.gap", LW'(pmem_read | pmem_write), '0);
    check_all("t_tie.gap");
    tick();
    check("t_tie.i_read", LW'(pmem_read), LW'(1'b1));
    check("t_tie.i_addr", LW'(pmem_address), LW'(32'h100));
    check("t_tie.i_wdata", pmem_wdata, '0);
    pmem_resp = 1'b1; pmem_rdata = rand_line();
    #1; check_all("t_tie.i_resp");
    tick();
    clear_inputs();

    // Both held continuously: D, I, D, I
    do_reset();
    i_pmem_read = 1'b1; i_pmem_address = 32'h100;
    d_pmem_read = 1'b1; d_pmem_address = 32'h200;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("t_rr.addr%0d", k), LW'(pmem_address),
            LW'((k % 2 == 0) ? 32'h200 : 32'h100));
      check_all("t_rr.serve");
      pmem_resp = 1'b1;
      #1; check_all("t_rr.resp");
      tick();
      pmem_resp = 1'b0;
    end
    clear_inputs();

    // Address change mid-transaction is ignored
    do_reset();
    d_pmem_read = 1'b1; d_pmem_address = 32'h300;
    tick();
    d_pmem_address = 32'h400;
    for (int k = 0; k < 3; k++) begin
      #1; check($sformatf("t_hold.addr%0d", k), LW'(pmem_address), LW'(32'h300));
      tick();
    end
    pmem_resp = 1'b1;
    #1;
    check("t_hold.addr_resp", LW'(pmem_address), LW'(32'h300));
    check_all("t_hold.resp");
    tick();
    clear_inputs();

    // Reset while SERVE_I waits; late pmem_resp must be dropped
    do_reset();
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_2000;
    tick();
    tick();
    #2;
    do_reset();
    pmem_resp = 1'b1; pmem_rdata = rand_line();
    #1;
    check("t_rst.i_resp", LW'(i_pmem_resp), '0);
    check("t_rst.pmem_read", LW'(pmem_read), '0);
    check_all("t_rst.after");
    tick();
    check_all("t_rst.after2");
    clear_inputs();

    // Stray pmem_resp in IDLE
    for (int k = 0; k < 3; k++) begin
      pmem_resp = 1'b1; pmem_rdata = rand_line();
      #1;
      check("t_stray.resp", LW'(i_pmem_resp | d_pmem_resp), '0);
      check("t_stray.rw", LW'(pmem_read | pmem_write), '0);
      tick();
    end
    clear_inputs();

    // Randomized traffic
    i_done = 1'b0; d_done = 1'b0; d_while_i = 0; i_while_d = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (i_done) i_pmem_read = 1'b0;
      else if (!i_pmem_read && $urandom_range(0, 2) == 0) begin
        i_pmem_read = 1'b1; i_pmem_address = $urandom;
      end else if (i_pmem_read && $urandom_range(0, 7) == 0) i_pmem_address = $urandom;

      if (d_done) begin
        d_pmem_read = 1'b0; d_pmem_write = 1'b0;
      end else if (!(d_pmem_read || d_pmem_write) && $urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 3))
          0, 1:    begin d_pmem_read = 1'b1; d_pmem_write = 1'b0; end
          2:       begin d_pmem_read = 1'b0; d_pmem_write = 1'b1; end
          default: begin d_pmem_read = 1'b1; d_pmem_write = 1'b1; end
        endcase
        d_pmem_address = $urandom; d_pmem_wdata = rand_line();
      end else if ((d_pmem_read || d_pmem_write) && $urandom_range(0, 7) == 0) begin
        d_pmem_address = $urandom; d_pmem_wdata = rand_line();
      end

      pmem_resp  = ($urandom_range(0, 3) == 0);
      pmem_rdata = rand_line();
      #1;
      check_all("rand");

      // Fairness from observed completions: at most one competitor per wait.
      if (d_pmem_resp && i_pmem_read) d_while_i++;
      if (i_pmem_resp && (d_pmem_read || d_pmem_write)) i_while_d++;
      if (i_pmem_resp) begin
        check("rand.fair_i", LW'(d_while_i > 1), '0);
        d_while_i = 0;
      end
      if (d_pmem_resp) begin
        check("rand.fair_d", LW'(i_while_d > 1), '0);
        i_while_d = 0;
      end

      i_done = (m_owner == OWN_I) && pmem_resp;
      d_done = (m_owner == OWN_D) && pmem_resp;

      if ($urandom_range(0, 499) == 0) begin
        do_reset();
        i_done = 1'b0; d_done = 1'b0; d_while_i = 0; i_while_d = 0;
      end else begin
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
